execute_md: RTL and testbench

Multiply/divide unit with HI/LO registers. It sits alongside the ALU in the execute stage of the pipelined MIPS core and takes the already-forwarded operands from the execute-stage forwarding muxes. MULT/MULTU run over a parametrised multi-cycle datapath, and DIV/DIVU run on an iterative radix-2 divider. The unit raises a stall only when the instruction currently in E needs HI/LO or the unit itself; independent instructions proceed while an operation is in flight.

---
 rtl/execute_md_if.sv | 25 ++
 rtl/execute_md.sv | 207 ++++++++++++++++++++
 tb/tb_execute_md.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_md_if.sv
// execute_md_if: E-stage side-band bundle between the pipeline and the
// multiply/divide unit. The pipeline drives as master; execute_md is the slave.
interface execute_md_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       md_op_e;
  logic [1:0]       md_read_e;
  logic [WIDTH-1:0] src_a_e;
  logic [WIDTH-1:0] src_b_e;
  logic             hold_e;
  logic             flush_e;
  logic [WIDTH-1:0] md_result_e;
  logic             stall_md_o;
  logic             busy_o;

  modport master (
    output md_op_e, md_read_e, src_a_e, src_b_e, hold_e, flush_e,
    input  md_result_e, stall_md_o, busy_o
  );

  modport slave (
    input  md_op_e, md_read_e, src_a_e, src_b_e, hold_e, flush_e,
    output md_result_e, stall_md_o, busy_o
  );
endinterface

// File: rtl/execute_md.sv
// execute_md: HI/LO multiply/divide unit for the MIPS execute stage.
// MULT/MULTU complete after MUL_CYCLES cycles; DIV/DIVU use a WIDTH-step
// restoring divider on operand magnitudes followed by one sign-fix cycle.
// Optional divider: define MD_DIV_EN to compile it in. Without it DIV/DIVU
// decode as no-ops (no busy, no stall, HI/LO untouched).
module execute_md #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  execute_md_if.slave  md
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [1:0] RD_HI    = 2'b01;
  localparam logic [1:0] RD_LO    = 2'b10;

  // Counter must reach the longer of the multiply latency and the divide step count.
  localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DIV_FIX
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             signed_reg;

  logic is_mult, is_multu, is_mthi, is_mtlo;
  logic op_any, read_any, accept;

  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;

`ifdef MD_DIV_EN
  localparam logic [2:0]       OP_DIV   = 3'b011;
  localparam logic [2:0]       OP_DIVU  = 3'b100;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  logic             is_div, is_divu;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             q_neg, r_neg, div_zero;
  logic [WIDTH-1:0] fix_hi, fix_lo;
`endif

  // Decode the E-stage request; reserved codes fall through as "none".
  always_comb begin
    is_mult  = (md.md_op_e == OP_MULT);
    is_multu = (md.md_op_e == OP_MULTU);
    is_mthi  = (md.md_op_e == OP_MTHI);
    is_mtlo  = (md.md_op_e == OP_MTLO);
`ifdef MD_DIV_EN
    is_div   = (md.md_op_e == OP_DIV);
    is_divu  = (md.md_op_e == OP_DIVU);
    op_any   = is_mult | is_multu | is_div | is_divu | is_mthi | is_mtlo;
`else
    op_any   = is_mult | is_multu | is_mthi | is_mtlo;
`endif
    read_any = (md.md_read_e == RD_HI) | (md.md_read_e == RD_LO);
    accept   = (state_reg == ST_IDLE) & ~md.hold_e & ~md.flush_e;
  end

  // Only an instruction that touches HI/LO or the unit waits on a busy unit.
  assign md.busy_o     = busy_reg;
  assign md.stall_md_o = busy_reg & (op_any | read_any);

  // MFHI/MFLO read the architectural registers directly; no bypass.
  always_comb begin
    md.md_result_e = '0;
    if (md.md_read_e == RD_HI)      md.md_result_e = hi_reg;
    else if (md.md_read_e == RD_LO) md.md_result_e = lo_reg;
  end

  // Full-width product of the latched operands; extension chooses signedness.
  always_comb begin
    mul_a_ext = signed_reg ? {{WIDTH{op_a_reg[WIDTH-1]}}, op_a_reg} : {{WIDTH{1'b0}}, op_a_reg};
    mul_b_ext = signed_reg ? {{WIDTH{op_b_reg[WIDTH-1]}}, op_b_reg} : {{WIDTH{1'b0}}, op_b_reg};
    product   = mul_a_ext * mul_b_ext;
  end

`ifdef MD_DIV_EN
  // One restoring step per cycle plus the final sign and divide-by-zero fixup.
  always_comb begin
    a_mag_in = (is_div & md.src_a_e[WIDTH-1]) ? -md.src_a_e : md.src_a_e;
    b_mag    = (signed_reg & op_b_reg[WIDTH-1]) ? -op_b_reg : op_b_reg;
    shifted  = {rem_reg, quo_reg[WIDTH-1]};
    diff     = shifted - {1'b0, b_mag};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    end
    q_neg    = signed_reg & (op_a_reg[WIDTH-1] ^ op_b_reg[WIDTH-1]);
    r_neg    = signed_reg & op_a_reg[WIDTH-1];
    div_zero = (op_b_reg == '0);
    fix_lo   = div_zero ? '1 : (q_neg ? -quo_reg : quo_reg);
    fix_hi   = div_zero ? op_a_reg : (r_neg ? -rem_reg : rem_reg);
  end
`endif

  // Control FSM, HI/LO and operand latches; in-flight work ignores hold/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      signed_reg <= 1'b0;
`ifdef MD_DIV_EN
      rem_reg    <= '0;
      quo_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (is_mult | is_multu) begin
              op_a_reg   <= md.src_a_e;
              op_b_reg   <= md.src_b_e;
              signed_reg <= is_mult;
              cnt_reg    <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= ST_MUL;
            end
`ifdef MD_DIV_EN
            else if (is_div | is_divu) begin
              op_a_reg   <= md.src_a_e;
              op_b_reg   <= md.src_b_e;
              signed_reg <= is_div;
              quo_reg    <= a_mag_in;
              rem_reg    <= '0;
              cnt_reg    <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= ST_DIV;
            end
`endif
            else if (is_mthi) begin
              hi_reg <= md.src_a_e;
            end else if (is_mtlo) begin
              lo_reg <= md.src_a_e;
            end
          end
        end
        ST_MUL: begin
          if (cnt_reg == MUL_LAST) begin
            hi_reg    <= product[2*WIDTH-1:WIDTH];
            lo_reg    <= product[WIDTH-1:0];
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
`ifdef MD_DIV_EN
        ST_DIV: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (cnt_reg == DIV_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_DIV_FIX;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DIV_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
`endif
        default: begin
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed checks of execute_md (WIDTH=32, MUL_CYCLES=2).
// Divider scenarios run when MD_DIV_EN is defined; otherwise DIV/DIVU are
// checked to behave as no-ops.
module tb_execute_md;
  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 2;
  localparam int BOUND      = 200;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;
  localparam logic [1:0] RD_NONE  = 2'b00;
  localparam logic [1:0] RD_HI    = 2'b01;
  localparam logic [1:0] RD_LO    = 2'b10;
  localparam logic [1:0] RD_RSVD  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  execute_md_if #(.WIDTH(WIDTH)) md_bus();

  execute_md #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    md_bus.md_op_e   = op;
    md_bus.md_read_e = rd;
    md_bus.src_a_e   = a;
    md_bus.src_b_e   = b;
    md_bus.hold_e    = 1'b0;
    md_bus.flush_e   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] rd, output logic [31:0] v);
    md_bus.md_read_e = rd;
    #1;
    v = md_bus.md_result_e;
    md_bus.md_read_e = RD_NONE;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (md_bus.busy_o === 1'b1 && n < BOUND) begin
      n++;
      tick();
    end
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (md_bus.stall_md_o === 1'b1 && n < BOUND) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    drive(OP_MULT, RD_LO, 32'h5, 32'h7);
    #12;
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md_bus.busy_o); end
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", md_bus.stall_md_o); end
    md_bus.md_op_e = OP_NONE;
    read_reg(RD_NONE, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_result_none: got %h want 0", v); end
    read_reg(RD_HI, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", v); end
    read_reg(RD_LO, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", v); end
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", md_bus.busy_o); end
    $display("reset: released, busy=%b", md_bus.busy_o);
  endtask

  task automatic test_mult();
    logic [31:0] v;
    int n;
    logic [2:0] ops [2];
    logic [31:0] exp_hi [2];
    ops[0] = OP_MULT;  exp_hi[0] = 32'hFFFF_FFFF;
    ops[1] = OP_MULTU; exp_hi[1] = 32'h0000_0002;
    for (int i = 0; i < 2; i++) begin
      drive(ops[i], RD_NONE, 32'hFFFF_FFFE, 32'h3);
      tick();
      drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
      count_busy(n);
      checks++; if (n !== MUL_CYCLES) begin errors++; $display("FAIL mult_busy_cycles[%0d]: got %0d want %0d", i, n, MUL_CYCLES); end
      read_reg(RD_HI, v);
      checks++; if (v !== exp_hi[i]) begin errors++; $display("FAIL mult_hi[%0d]: got %h want %h", i, v, exp_hi[i]); end
      read_reg(RD_LO, v);
      checks++; if (v !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo[%0d]: got %h want fffffffa", i, v); end
      $display("mult op=%0d a=fffffffe b=3 busy=%0d lo=%h", ops[i], n, v);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(OP_MULT, RD_NONE, 32'd7, 32'd6);
    tick();
    drive(OP_NONE, RD_LO, 32'h0, 32'h0);
    count_stall(n);
    checks++; if (n !== MUL_CYCLES) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want %0d", n, MUL_CYCLES); end
    checks++; if (md_bus.md_result_e !== 32'd42) begin errors++; $display("FAIL b2b_mflo: got %h want 0000002a", md_bus.md_result_e); end
    $display("mult->mflo stall=%0d result=%h", n, md_bus.md_result_e);
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_independent();
    int n;
    logic [31:0] v;
    drive(OP_MULT, RD_NONE, 32'd2, 32'd3);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    #1;
    checks++; if (md_bus.busy_o !== 1'b1) begin errors++; $display("FAIL indep_busy: got %b want 1", md_bus.busy_o); end
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL indep_add_stall: got %b want 0", md_bus.stall_md_o); end
    md_bus.md_op_e = OP_RSVD;
    #1;
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL indep_rsvd_op_stall: got %b want 0", md_bus.stall_md_o); end
    md_bus.md_op_e = OP_NONE; md_bus.md_read_e = RD_RSVD;
    #1;
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL indep_rsvd_read_stall: got %b want 0", md_bus.stall_md_o); end
    md_bus.md_read_e = RD_NONE; md_bus.md_op_e = OP_MTHI;
    #1;
    checks++; if (md_bus.stall_md_o !== 1'b1) begin errors++; $display("FAIL indep_mthi_stall: got %b want 1", md_bus.stall_md_o); end
    md_bus.md_op_e = OP_NONE;
    count_busy(n);
    read_reg(RD_LO, v);
    checks++; if (v !== 32'd6) begin errors++; $display("FAIL indep_lo: got %h want 00000006", v); end
    $display("independent op during mult: lo=%h", v);
  endtask

  task automatic test_mtlo();
    logic [31:0] v;
    drive(OP_MTLO, RD_NONE, 32'h1111_1111, 32'h0);
    tick();
    drive(OP_MTLO, RD_LO, 32'h1234_5678, 32'h0);
    #1;
    checks++; if (md_bus.md_result_e !== 32'h1111_1111) begin errors++; $display("FAIL mtlo_no_bypass: got %h want 11111111", md_bus.md_result_e); end
    tick();
    drive(OP_NONE, RD_LO, 32'h0, 32'h0);
    #1;
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %b want 0", md_bus.stall_md_o); end
    checks++; if (md_bus.md_result_e !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_mflo: got %h want 12345678", md_bus.md_result_e); end
    drive(OP_MTHI, RD_NONE, 32'hCAFE_0001, 32'h0);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", md_bus.busy_o); end
    read_reg(RD_HI, v);
    checks++; if (v !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi_mfhi: got %h want cafe0001", v); end
    $display("mtlo/mthi: lo=12345678 hi=%h", v);
  endtask

  task automatic test_hold();
    int n;
    logic [31:0] v;
    drive(OP_MULT, RD_NONE, 32'd11, 32'd13);
    md_bus.hold_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL hold_busy[%0d]: got %b want 0", i, md_bus.busy_o); end
    end
    md_bus.hold_e = 1'b0;
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    count_busy(n);
    checks++; if (n !== MUL_CYCLES) begin errors++; $display("FAIL hold_busy_cycles: got %0d want %0d", n, MUL_CYCLES); end
    tick();
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL hold_single_start: got %b want 0", md_bus.busy_o); end
    read_reg(RD_LO, v);
    checks++; if (v !== 32'd143) begin errors++; $display("FAIL hold_lo: got %h want 0000008f", v); end
    $display("held mult: busy=%0d lo=%h", n, v);
  endtask

  task automatic test_flush();
    logic [31:0] v;
    drive(OP_MTHI, RD_NONE, 32'hAAAA_5555, 32'h0); tick();
    drive(OP_MTLO, RD_NONE, 32'h0F0F_0F0F, 32'h0); tick();
`ifdef MD_DIV_EN
    drive(OP_DIV, RD_NONE, 32'd100, 32'd7);
`else
    drive(OP_MULT, RD_NONE, 32'd100, 32'd7);
`endif
    md_bus.flush_e = 1'b1;
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", md_bus.busy_o); end
    tick();
    read_reg(RD_HI, v);
    checks++; if (v !== 32'hAAAA_5555) begin errors++; $display("FAIL flush_hi: got %h want aaaa5555", v); end
    read_reg(RD_LO, v);
    checks++; if (v !== 32'h0F0F_0F0F) begin errors++; $display("FAIL flush_lo: got %h want 0f0f0f0f", v); end
    $display("flushed op: hi/lo unchanged lo=%h", v);
  endtask

`ifdef MD_DIV_EN
  task automatic test_div();
    int n;
    logic [31:0] v;
    drive(OP_DIV, RD_NONE, 32'hFFFF_FFF9, 32'd2);
    tick();
    drive(OP_NONE, RD_LO, 32'h0, 32'h0);
    count_stall(n);
    checks++; if (n !== WIDTH + 1) begin errors++; $display("FAIL div_stall_cycles: got %0d want %0d", n, WIDTH + 1); end
    checks++; if (md_bus.md_result_e !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", md_bus.md_result_e); end
    read_reg(RD_HI, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", v); end
    $display("div -7/2 stall=%0d hi=%h", n, v);

    drive(OP_DIVU, RD_NONE, 32'd5, 32'd0);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    count_busy(n);
    checks++; if (n !== WIDTH + 1) begin errors++; $display("FAIL divz_busy_cycles: got %0d want %0d", n, WIDTH + 1); end
    read_reg(RD_LO, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", v); end
    read_reg(RD_HI, v);
    checks++; if (v !== 32'h0000_0005) begin errors++; $display("FAIL divz_hi: got %h want 00000005", v); end
    $display("divu 5/0 hi=%h", v);

    drive(OP_DIV, RD_NONE, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    count_busy(n);
    read_reg(RD_LO, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", v); end
    read_reg(RD_HI, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h want 00000000", v); end
    $display("div 80000000/ffffffff hi=%h", v);
  endtask
`else
  task automatic test_div_disabled();
    int n;
    logic [31:0] v;
    drive(OP_MTHI, RD_NONE, 32'h0000_1111, 32'h0); tick();
    drive(OP_MTLO, RD_NONE, 32'h0000_2222, 32'h0); tick();
    drive(OP_DIVU, RD_NONE, 32'd9, 32'd3);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL nodiv_busy: got %b want 0", md_bus.busy_o); end
    tick();
    read_reg(RD_HI, v);
    checks++; if (v !== 32'h0000_1111) begin errors++; $display("FAIL nodiv_hi: got %h want 00001111", v); end
    read_reg(RD_LO, v);
    checks++; if (v !== 32'h0000_2222) begin errors++; $display("FAIL nodiv_lo: got %h want 00002222", v); end
    drive(OP_MULT, RD_NONE, 32'd4, 32'd4);
    tick();
    drive(OP_DIV, RD_NONE, 32'd9, 32'd3);
    #1;
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL nodiv_stall: got %b want 0", md_bus.stall_md_o); end
    md_bus.md_op_e = OP_NONE;
    count_busy(n);
    read_reg(RD_LO, v);
    checks++; if (v !== 32'd16) begin errors++; $display("FAIL nodiv_mult_lo: got %h want 00000010", v); end
    $display("divu 9/3 without divider: ignored, mult lo=%h", v);
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    logic [31:0] v;
`ifdef MD_DIV_EN
    drive(OP_DIV, RD_NONE, 32'd1000, 32'd7);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
`else
    drive(OP_MULT, RD_NONE, 32'd1000, 32'd7);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
`endif
    md_bus.md_read_e = RD_LO;
    #1;
    checks++; if (md_bus.stall_md_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: got %b want 1", md_bus.stall_md_o); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (md_bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", md_bus.busy_o); end
    checks++; if (md_bus.stall_md_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", md_bus.stall_md_o); end
    checks++; if (md_bus.md_result_e !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", md_bus.md_result_e); end
    read_reg(RD_HI, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", v); end
    rst_n = 1'b1;
    tick();
    drive(OP_MULT, RD_NONE, 32'd9, 32'd5);
    tick();
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    count_busy(n);
    checks++; if (n !== MUL_CYCLES) begin errors++; $display("FAIL rstmid_mult_busy: got %0d want %0d", n, MUL_CYCLES); end
    read_reg(RD_LO, v);
    checks++; if (v !== 32'd45) begin errors++; $display("FAIL rstmid_mult_lo: got %h want 0000002d", v); end
    $display("reset mid-op, then mult 9*5 lo=%h", v);
  endtask

  initial begin
    drive(OP_NONE, RD_NONE, 32'h0, 32'h0);
    test_reset();
    test_mult();
    test_back_to_back();
    test_independent();
    test_mtlo();
    test_hold();
    test_flush();
`ifdef MD_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
